// File: rtl/koto_cnt_pkg.sv
// Shared definitions for the L1 event counter array and its readout block.
package koto_cnt_pkg;

    // Counting modes selectable through the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Default geometry, kept here so the readout block agrees with the counters
    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_NCH   = 4;

    // All-ones preset of the given width; callers truncate to their own width
    function automatic logic [63:0] CNT_PRESET(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/event_chan_counter.sv
// One event channel: input synchroniser, rising-edge detect, counter with
// started and sticky overflow flags.
module event_chan_counter
    import koto_cnt_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             live,
    input  logic             evt_in,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             started,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] PRESET = WIDTH'(CNT_PRESET(WIDTH));

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_s;
    logic                   rise;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~hist_q;

    // Synchroniser chain and edge history; runs regardless of live
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in};
            hist_q <= sync_s;
        end
    end

    // Counter, started and sticky overflow; an overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= PRESET;
            started <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (clr_ovf) begin
                ovf <= 1'b0;
            end
            if (!live) begin
                cnt     <= PRESET;
                started <= 1'b0;
            end else if (rise) begin
                if (!started) begin
                    cnt     <= '0;
                    started <= 1'b1;
                end else if (cnt != PRESET) begin
                    cnt <= cnt + WIDTH'(1);
                end else begin
                    ovf <= 1'b1;
                    if (SATURATE == MODE_WRAP) begin
                        cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/l1_event_counter_array.sv
// NCH independent event counters plus a coherent all-channel snapshot
// register for readout on an L1 accept.
module l1_event_counter_array
    import koto_cnt_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int NCH         = DEFAULT_NCH,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 live,
    input  logic [NCH-1:0]       evt_in,
    input  logic                 snap,
    input  logic                 clr_ovf,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       started,
    output logic [NCH-1:0]       ovf,
    output logic [NCH*WIDTH-1:0] snap_cnt,
    output logic                 snap_valid
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        event_chan_counter #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .SATURATE    (SATURATE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .live    (live),
            .evt_in  (evt_in[i]),
            .clr_ovf (clr_ovf),
            .cnt     (cnt[i*WIDTH +: WIDTH]),
            .started (started[i]),
            .ovf     (ovf[i])
        );
    end

    // Snapshot captures the registered counts, so a coinciding rise is excluded
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_cnt   <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= snap;
            if (snap) begin
                snap_cnt <= cnt;
            end
        end
    end

endmodule
